// File: rtl/sqrt_issue_ctrl.sv
// Round-robin front end for one shared sqrt / inverse-sqrt unit: one op in flight,
// IEEE special operands answered locally, watchdog on the unit's result strobe.
module sqrt_issue_ctrl #(
   parameter int N_REQ   = 2,
   parameter int E_DW    = 8,
   parameter int F_DW    = 7,
   parameter int TMO_CYC = 64,
   localparam int ID_W   = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid_i,
   output logic [N_REQ-1:0]          req_ready_o,
   input  logic [N_REQ-1:0]          req_inv_i,
   input  logic [N_REQ-1:0]          req_s_i,
   input  logic [N_REQ*E_DW-1:0]     req_e_i,
   input  logic [N_REQ*(F_DW+1)-1:0] req_f_i,
   input  logic [N_REQ*4-1:0]        req_cls_i,
   output logic                      unit_do_o,
   output logic                      unit_doinv_o,
   output logic                      unit_s_o,
   output logic [E_DW-1:0]           unit_e_o,
   output logic [F_DW:0]             unit_f_o,
   input  logic                      unit_valid_i,
   input  logic                      unit_s_i,
   input  logic [E_DW-1:0]           unit_e_i,
   input  logic [F_DW+4:0]           unit_f_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [ID_W-1:0]           rsp_id_o,
   output logic                      rsp_s_o,
   output logic [E_DW-1:0]           rsp_e_o,
   output logic [F_DW+4:0]           rsp_f_o,
   output logic [1:0]                rsp_spc_o,
   output logic                      rsp_err_o
);
   localparam int CNT_W = $clog2(TMO_CYC);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef struct packed {
      logic            inv;
      logic            s;
      logic [E_DW-1:0] e;
      logic [F_DW:0]   f;
   } op_t;
   typedef struct packed {
      logic            s;
      logic [E_DW-1:0] e;
      logic [F_DW+4:0] f;
      logic [1:0]      spc;
      logic            err;
   } rsp_t;

   state_t          state_q, state_d;
   op_t             op_q, op_in;
   rsp_t            rsp_q, rsp_spc;
   logic [ID_W-1:0] rr_ptr, gnt, gnt_inc, idx, id_q;
   logic [CNT_W-1:0] cnt_q, cnt_inc;
   logic [3:0]      cls_in;
   logic            any_req, spc_hit, tmo;

   // first pending requester at or after rr_ptr, wrapping
   always_comb begin
      any_req = 1'b0;
      gnt     = '0;
      idx     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
         if (!any_req && req_valid_i[idx]) begin
            any_req = 1'b1;
            gnt     = idx;
         end
      end
   end

   assign gnt_inc = (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + 1'b1;

   always_comb begin
      op_in  = '0;
      cls_in = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt == ID_W'(i)) begin
            op_in.inv = req_inv_i[i];
            op_in.s   = req_s_i[i];
            op_in.e   = req_e_i[i*E_DW +: E_DW];
            op_in.f   = req_f_i[i*(F_DW+1) +: F_DW+1];
            cls_in    = req_cls_i[i*4 +: 4];
         end
      end
   end

   // cls_in = {isZ, isInf, isSNAN, isQNAN}; any negative nonzero operand is invalid
   always_comb begin
      rsp_spc = '0;
      spc_hit = |cls_in | op_in.s;
      if (cls_in[1] | cls_in[0] | (op_in.s & ~cls_in[3])) begin
         rsp_spc.spc = 2'b11;
      end else if (cls_in[3]) begin
         rsp_spc.spc = op_in.inv ? 2'b10 : 2'b01;
         rsp_spc.s   = op_in.s;
      end else if (cls_in[2]) begin
         rsp_spc.spc = op_in.inv ? 2'b01 : 2'b10;
      end
   end

   assign cnt_inc = cnt_q + 1'b1;
   assign tmo     = (cnt_inc == CNT_W'(TMO_CYC-1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (any_req) state_d = spc_hit ? RESP : ISSUE;
         ISSUE: state_d = WAIT;
         WAIT:  if (unit_valid_i || tmo) state_d = RESP;
         RESP:  if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o  = '0;
      if (state_q == IDLE && any_req && !rst) req_ready_o[gnt] = 1'b1;
      unit_do_o    = (state_q == ISSUE) && !op_q.inv;
      unit_doinv_o = (state_q == ISSUE) &&  op_q.inv;
      rsp_valid_o  = (state_q == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         rsp_q  <= '0;
         id_q   <= '0;
         rr_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (any_req) begin
               op_q   <= op_in;
               id_q   <= gnt;
               rr_ptr <= gnt_inc;
               rsp_q  <= rsp_spc;
            end
            ISSUE: cnt_q <= '0;
            WAIT: begin
               if (unit_valid_i) begin
                  rsp_q.s   <= unit_s_i;
                  rsp_q.e   <= unit_e_i;
                  rsp_q.f   <= unit_f_i;
                  rsp_q.spc <= 2'b00;
                  rsp_q.err <= 1'b0;
               end else if (tmo) begin
                  rsp_q.s   <= 1'b0;
                  rsp_q.e   <= '0;
                  rsp_q.f   <= '0;
                  rsp_q.spc <= 2'b11;
                  rsp_q.err <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            RESP: if (rsp_ready_i) rsp_q.err <= 1'b0;
            default: ;
         endcase
      end
   end

   assign unit_s_o  = op_q.s;
   assign unit_e_o  = op_q.e;
   assign unit_f_o  = op_q.f;
   assign rsp_id_o  = id_q;
   assign rsp_s_o   = rsp_q.s;
   assign rsp_e_o   = rsp_q.e;
   assign rsp_f_o   = rsp_q.f;
   assign rsp_spc_o = rsp_q.spc;
   assign rsp_err_o = rsp_q.err;
endmodule
